// File: rtl/rice_residual_decoder.sv
// rice_residual_decoder: serial Rice decoder for one FLAC residual partition,
// emitting zigzag-unfolded signed residuals with a one-cycle valid strobe.
module rice_residual_decoder #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iStart,
   input  logic [3:0]        iRiceParam,
   input  logic [CNT_W-1:0]  iCount,
   input  logic              iBit,
   input  logic              iBitValid,
   output logic [DATA_W-1:0] oData,
   output logic              oValid,
   output logic              oBusy,
   output logic              oDone,
   output logic              oError
);
   localparam int UW = DATA_W + 15;
   typedef enum logic [1:0] {IDLE, UNARY, REM} state_t;
   state_t             state;
   logic [3:0]         k;
   logic [3:0]         bits;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W:0]    q;
   logic [13:0]        r;
   logic [UW-1:0]      u;
   logic [DATA_W-1:0]  half;
   logic               fin;
   logic               ovf;
   // r holds only k-1 bits when the final remainder bit arrives, so {r, iBit} is the full remainder
   assign fin   = iBitValid && ((state == UNARY && iBit && k == 4'd0) ||
                                (state == REM && bits == k - 4'd1));
   assign u     = (UW'(q) << k) | (state == REM ? UW'({r, iBit}) : '0);
   assign ovf   = |u[UW-1:DATA_W];
   assign half  = u[DATA_W:1];
   assign oBusy = state != IDLE;
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state  <= IDLE;
         k      <= '0;
         bits   <= '0;
         cnt    <= '0;
         q      <= '0;
         r      <= '0;
         oData  <= '0;
         oValid <= 1'b0;
         oDone  <= 1'b0;
         oError <= 1'b0;
      end else begin
         oValid <= 1'b0;
         oDone  <= 1'b0;
         case (state)
            IDLE: if (iStart) begin
               oError <= iRiceParam == 4'd15;
               if (iRiceParam != 4'd15) begin
                  if (iCount == '0) oDone <= 1'b1;
                  else begin
                     state <= UNARY;
                     k     <= iRiceParam;
                     cnt   <= iCount;
                     q     <= '0;
                  end
               end
            end
            UNARY: if (iBitValid) begin
               if (!iBit) q <= q[DATA_W] ? q : q + 1'b1;
               else if (k != 4'd0) begin
                  state <= REM;
                  r     <= '0;
                  bits  <= '0;
               end
            end
            REM: if (iBitValid) begin
               r    <= {r[12:0], iBit};
               bits <= bits + 4'd1;
            end
            default: state <= IDLE;
         endcase
         // Residual completion overrides the per-state updates above
         if (fin) begin
            if (ovf) begin
               oError <= 1'b1;
               state  <= IDLE;
            end else begin
               oValid <= 1'b1;
               oData  <= u[0] ? ~half : half;
               cnt    <= cnt - 1'b1;
               q      <= '0;
               if (cnt == CNT_W'(1)) begin
                  oDone <= 1'b1;
                  state <= IDLE;
               end else state <= UNARY;
            end
         end
      end
   end
endmodule

// File: tb/tb_rice_residual_decoder.sv
// tb_rice_residual_decoder: directed and randomized partitions checked against
// a bit-level Rice encoder model with per-bit expected strobes.
module tb_rice_residual_decoder;
   logic        iClock = 1'b0;
   logic        iReset, iStart, iBit, iBitValid;
   logic [3:0]  iRiceParam;
   logic [15:0] iCount;
   logic [15:0] oData;
   logic        oValid, oBusy, oDone, oError;
   int checks = 0;
   int errors = 0;
   bit qb[$];
   bit qe[$];
   bit qd[$];
   int qv[$];

   rice_residual_decoder #(.DATA_W(16), .CNT_W(16)) dut (
      .iClock(iClock), .iReset(iReset), .iStart(iStart), .iRiceParam(iRiceParam),
      .iCount(iCount), .iBit(iBit), .iBitValid(iBitValid), .oData(oData),
      .oValid(oValid), .oBusy(oBusy), .oDone(oDone), .oError(oError));

   always #5 iClock = ~iClock;

   function automatic int unfold(int u);
      return (u % 2 != 0) ? -(u / 2) - 1 : u / 2;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge iClock);
      #1;
   endtask

   task automatic start(int k, int n);
      iRiceParam = 4'(k);
      iCount     = 16'(n);
      iStart     = 1'b1;
      tick;
      iStart = 1'b0;
      chk("busy_after_start", 32'(oBusy), 32'(k != 15 && n != 0));
   endtask

   task automatic push(bit b, bit e, bit d, int v);
      qb.push_back(b);
      qe.push_back(e);
      qd.push_back(d);
      qv.push_back(v);
   endtask

   // Rice code of unfolded value u: (u>>k) zeros, a one, then the low k bits MSB first
   task automatic encode_u(int u, int k, bit ok, bit last);
      for (int i = 0; i < (u >> k); i++) push(1'b0, 1'b0, 1'b0, 0);
      if (k == 0) push(1'b1, ok, ok && last, unfold(u));
      else begin
         push(1'b1, 1'b0, 1'b0, 0);
         for (int i = k - 1; i >= 0; i--)
            push(bit'((u >> i) & 1), ok && i == 0, ok && last && i == 0, unfold(u));
      end
   endtask

   task automatic encode(int v, int k, bit last);
      encode_u(v >= 0 ? 2 * v : -2 * v - 1, k, 1'b1, last);
   endtask

   task automatic stall(int n);
      for (int i = 0; i < n; i++) begin
         iBitValid = 1'b0;
         iBit      = 1'($urandom);
         tick;
         chk("stall_valid", 32'(oValid), 32'(0));
      end
   endtask

   task automatic run(int max_bits, int max_res, int stall_pct);
      int nb = 0;
      int nr = 0;
      bit e, d;
      int v;
      while (qb.size() > 0 && nb < max_bits && nr < max_res) begin
         if ($urandom_range(0, 99) < stall_pct) stall($urandom_range(1, 2));
         iBit      = qb.pop_front();
         e         = qe.pop_front();
         d         = qd.pop_front();
         v         = qv.pop_front();
         iBitValid = 1'b1;
         tick;
         iBitValid = 1'b0;
         chk("valid", 32'(oValid), 32'(e));
         chk("done", 32'(oDone), 32'(d));
         if (e) chk("data", 32'($signed(oData)), v);
         nb++;
         if (e) nr++;
      end
   endtask

   task automatic clear_model;
      qb.delete();
      qe.delete();
      qd.delete();
      qv.delete();
   endtask

   initial begin
      int k, n, u;
      iReset = 1'b1; iStart = 1'b0; iBit = 1'b0; iBitValid = 1'b0;
      iRiceParam = '0; iCount = '0;
      tick; tick;
      chk("rst_data", 32'(oData), 32'(0));
      chk("rst_valid", 32'(oValid), 32'(0));
      chk("rst_busy", 32'(oBusy), 32'(0));
      chk("rst_done", 32'(oDone), 32'(0));
      chk("rst_error", 32'(oError), 32'(0));
      iReset = 1'b0;
      // u=5 with k=2: bits 0,1,0,1 -> -3, done with the strobe
      start(2, 1);
      encode(-3, 2, 1'b1);
      run(1000, 1000, 0);
      chk("t1_busy_end", 32'(oBusy), 32'(0));
      // k=0 continuous ones: strobe every cycle
      start(0, 3);
      for (int i = 0; i < 3; i++) encode(0, 0, i == 2);
      run(1000, 1000, 0);
      chk("t2_busy_end", 32'(oBusy), 32'(0));
      // k=3, stall two cycles inside the first residual
      start(3, 2);
      encode(7, 3, 1'b0);
      encode(0, 3, 1'b1);
      run(3, 1000, 0);
      stall(2);
      chk("t3_busy_stall", 32'(oBusy), 32'(1));
      run(1000, 1000, 0);
      chk("t3_busy_end", 32'(oBusy), 32'(0));
      // Largest in-range value u=65535 -> -32768
      start(14, 1);
      encode_u(65535, 14, 1'b1, 1'b1);
      run(1000, 1000, 0);
      chk("max_err", 32'(oError), 32'(0));
      // u=65536 overflows: error, no strobe, no done
      start(14, 1);
      encode_u(65536, 14, 1'b0, 1'b0);
      run(1000, 1000, 0);
      chk("ovf_err", 32'(oError), 32'(1));
      chk("ovf_busy", 32'(oBusy), 32'(0));
      tick;
      chk("ovf_valid_after", 32'(oValid), 32'(0));
      chk("ovf_err_sticky", 32'(oError), 32'(1));
      // Escape parameter is rejected
      start(15, 5);
      chk("esc_err", 32'(oError), 32'(1));
      chk("esc_done", 32'(oDone), 32'(0));
      // Empty partition: done next cycle, error cleared, no strobe
      start(1, 0);
      chk("empty_err", 32'(oError), 32'(0));
      chk("empty_done", 32'(oDone), 32'(1));
      chk("empty_valid", 32'(oValid), 32'(0));
      tick;
      chk("empty_done_pulse", 32'(oDone), 32'(0));
      // Reset mid-partition with an ignored iStart while busy
      start(4, 10);
      for (int i = 0; i < 10; i++) encode(int'($urandom_range(0, 200)) - 100, 4, i == 9);
      run(100000, 3, 0);
      iRiceParam = 4'd0; iCount = 16'd1; iStart = 1'b1;
      tick;
      iStart = 1'b0;
      chk("busy_ignored_start", 32'(oBusy), 32'(1));
      run(100000, 1, 0);
      iReset = 1'b1;
      tick;
      iReset = 1'b0;
      chk("mid_rst_data", 32'(oData), 32'(0));
      chk("mid_rst_valid", 32'(oValid), 32'(0));
      chk("mid_rst_busy", 32'(oBusy), 32'(0));
      chk("mid_rst_done", 32'(oDone), 32'(0));
      chk("mid_rst_err", 32'(oError), 32'(0));
      clear_model;
      // Randomized partitions with random stalls
      for (int p = 0; p < 8; p++) begin
         k = $urandom_range(0, 14);
         n = $urandom_range(1, 6);
         start(k, n);
         for (int i = 0; i < n; i++) begin
            u = (int'($urandom_range(0, 3)) << k) | int'($urandom & ((1 << k) - 1));
            if (u > 65535) u = 65535;
            encode_u(u, k, 1'b1, i == n - 1);
         end
         run(100000, 1000, 20);
         chk("rand_busy_end", 32'(oBusy), 32'(0));
         chk("rand_err", 32'(oError), 32'(0));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rice_residual_decoder.md
Name: rice_residual_decoder

Overview:
- Upstream stage of the fixed-predictor decoder.
- Consumes the FLAC residual bitstream serially, one bit per cycle, MSB first, and decodes Rice-coded residuals for one partition.
- Emits signed 16-bit residuals with a one-cycle valid strobe. The strobe drives the predictor's sample and enable inputs directly.
- Partition parameters (Rice parameter, residual count) are latched at start; the block reports done and error status to the frame controller.

Parameters:
- DATA_W, 16, residual output width; the unfolded value u must fit in DATA_W bits.
- CNT_W, 16, width of the residual count input and internal counter.

Ports:
- iClock  in  1  clock; all logic on rising edge.
- iReset  in  1  reset, synchronous, active-high.
- iStart  in  1  one-cycle pulse: latch iRiceParam/iCount and begin the partition; ignored unless idle.
- iRiceParam  in  4  Rice parameter k, 0..14; 15 (escape code) is unsupported.
- iCount  in  CNT_W  number of residuals to decode in this partition.
- iBit  in  1  next bitstream bit.
- iBitValid  in  1  iBit is valid this cycle; always accepted while busy, ignored when idle.
- oData  out  DATA_W  signed residual; held between strobes.
- oValid  out  1  one-cycle pulse: oData is a new residual.
- oBusy  out  1  high from the cycle after an accepted iStart until done or error.
- oDone  out  1  one-cycle pulse: partition complete.
- oError  out  1  sticky error flag; cleared by iReset or an accepted iStart.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, UNARY, REM.
- IDLE:
  - iStart with k<=14 and iCount>0: latch k and count, go to UNARY, clear quotient q and oError.
  - iStart with iCount==0: stay IDLE, pulse oDone next cycle, no oValid.
  - iStart with k==15: stay IDLE, set oError, no oDone.
- UNARY, per accepted bit:
  - 0: q <= q+1, saturating at 2^DATA_W.
  - 1: if k==0, the residual ends on this bit; else clear the remainder register and bit counter, go to REM.
- REM, per accepted bit:
  - Shift the bit into the remainder register r (MSB first).
  - After the k-th bit, the residual ends on this bit.
- Residual end:
  - u = (q << k) | r, evaluated at >= DATA_W+15 bits.
  - If u >= 2^DATA_W: set oError, drop oBusy, go to IDLE, no oValid, no oDone.
  - Otherwise, next cycle: oValid=1 and oData = u[0] ? -(u>>1)-1 : (u>>1), i.e. zigzag unfold. Example: u=5 -> -3, u=65535 -> -32768.
  - Decrement the remaining count. If it reaches 0, oDone pulses in the same cycle as oValid, oBusy drops, go to IDLE. Else clear q and go to UNARY.
- Latency: exactly 1 cycle from the cycle the final bit of a residual is accepted to oValid.
- Throughput: one residual per (q+1+k) accepted bits; back-to-back residuals with no bubble. With k=0 and a continuous "1" stream, oValid is high every cycle.
- iBitValid low: state and counters hold; a pending oValid still fires on schedule.
- iStart while busy: ignored; the current partition is unaffected.
- iReset mid-partition: immediate return to IDLE next edge, all outputs 0; no oDone.
- oData keeps its last value when oValid is low.

Test Plan:
- Reset, then iStart k=2 iCount=1, bits 0,1,0,1 -> one cycle after the 4th bit: oValid=1, oData=-3 (u=5), oDone=1 same cycle, oBusy falls.
- iStart k=0 iCount=3, bits 1,1,1 continuous -> oValid on 3 consecutive cycles, oData=0,0,0; oDone with the third.
- iStart k=3 iCount=2, bits 0,1,1,1,0 then 1,0,0,0 with iBitValid low for 2 cycles mid-stream -> residuals 7 (u=14) then 0; no output during stall; oDone with the second.
- iStart k=0 iCount=1, 65535 zeros then 1 -> oData=-32768; repeat with 65536 zeros then 1 -> oError=1, no oValid, no oDone, IDLE.
- iStart k=15 -> oError=1, oBusy stays 0. Then iStart k=1 iCount=0 -> oError clears, oDone pulses next cycle, no oValid.
- Mid-partition (k=4, iCount=10, after 3 residuals) assert iReset one cycle -> all outputs 0, second iStart during the earlier busy period had no effect; fresh partition then decodes correctly.
